sr_mdu_seq: RTL and testbench
=============================

// Module: sr_mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the schoolRISCV core (RV32M subset: MUL, MULHU, DIVU, REMU).
//  - Accepts one operation from sr_control/datapath, computes 1 bit per cycle, returns result with done pulse.
//  - busy is used by the core to stall PC update and regfile write-back until done.
// PARAMETERS
//  WIDTH  32  operand/result width; must be >= 2
// PORTS
//  clk      in   1      core clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; accepted only when state==IDLE and flush==0
//  op       in   2      00 MUL (low), 01 MULHU (high, unsigned), 10 DIVU, 11 REMU; sampled at accept
//  srcA     in   WIDTH  multiplicand / dividend; sampled at accept
//  srcB     in   WIDTH  multiplier / divisor; sampled at accept
//  flush    in   1      abort current operation (pipeline redirect)
//  busy     out  1      1 in RUN and DONE; 0 in IDLE
//  done     out  1      one-cycle pulse; result valid in that cycle
//  result   out  WIDTH  final value; held stable from done until next accept
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, all internal regs 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: on accept latch op/srcA/srcB, count=WIDTH; go RUN (or DONE directly for divide-by-zero).
//    RUN: one iteration per cycle, count decrements; when count reaches 0 (after WIDTH iterations) go DONE.
//    DONE: done=1 for exactly one cycle, result updated on entry; next cycle IDLE.
//  - Latency: accept at cycle N -> done at cycle N+WIDTH+1 (33 for WIDTH=32); div-by-zero: done at N+1.
//  - start while busy=1 is ignored (no queuing); back-to-back: new accept allowed the cycle after DONE.
//  - MUL/MULHU: 2*WIDTH product reg {hi,lo}, lo=srcB at accept; each iteration: if lo[0] hi+=srcA
//    (WIDTH+1-bit sum, carry kept), then shift {carry,hi,lo} right 1. MUL=lo, MULHU=hi. Unsigned.
//  - DIVU/REMU: restoring; rem (WIDTH+1 bits)=0, quo=srcA; each iteration: shift {rem,quo} left 1;
//    if rem>=srcB then rem-=srcB, quo[0]=1. DIVU=quo, REMU=rem[WIDTH-1:0].
//  - Divide by zero (srcB==0): DIVU -> all ones, REMU -> srcA (RISC-V semantics); no overflow case (unsigned).
//  - flush=1: state->IDLE next edge from any state, done not asserted, result keeps previous value;
//    flush and start same cycle in IDLE: flush wins, request not accepted.
//  - flush in DONE cycle: done still 1 that cycle (already committed), then IDLE.
//  - op values are all legal; no error output.
// CONFIGURATION
//  SR_MDU_EARLY_OUT_EN defined:
//   - MUL/MULHU: in RUN, if remaining multiplier bits lo[count-1:0]==0, product is shifted right
//     by count in one cycle and FSM goes to DONE; srcB==0 -> done at N+2; srcB==1 -> done at N+3.
//   - DIVU/REMU unchanged; results identical to non-early-out build.
//  Not defined: every non-div-by-zero operation takes exactly WIDTH RUN cycles; no barrel shifter.
// TESTING
//  1. Reset mid-RUN: start MUL, drop rst_n at iteration 10 -> busy=0, done=0, result=0 immediately.
//  2. MUL 7*6 -> result=42 at cycle N+33, done one cycle; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF at N+1; REMU 5/0 -> 5 at N+1.
//  4. start pulsed every cycle during RUN with other operands -> ignored; first result unchanged;
//     start held through DONE -> new accept on the cycle after DONE.
//  5. flush at iteration 5 of DIVU -> IDLE next cycle, no done, result keeps prior 42; flush+start in IDLE -> busy stays 0.
//  6. With SR_MDU_EARLY_OUT_EN: MUL 0x1234*0 -> 0 at N+2; MUL 3*2 -> 6 before N+33; random 1000 ops match model in both builds.

Source files
------------

// File: rtl/sr_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer (MUL, MULHU, DIVU, REMU), one bit per cycle.
// Optional define SR_MDU_EARLY_OUT_EN: finish a multiply early once the remaining multiplier bits are zero.
module sr_mdu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       opReg;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;
    logic             finish;
    logic [WIDTH-1:0] resNext;

    // accHi/accLo hold {hi,lo} for multiply and {rem,quo} for divide; operand is srcA or the divisor.
    // The partial remainder is always below the divisor, so its extra top bit only exists pre-compare.
`ifdef SR_MDU_EARLY_OUT_EN
    logic [WIDTH-1:0]   remMask;
    logic [2*WIDTH-1:0] shifted;
    logic               mulIdle;
`endif

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = (divShift >= {1'b0, operand});
        if (!opReg[1]) begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end else begin
            nextHi = divFits ? WIDTH'(divShift - {1'b0, operand}) : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divFits};
        end
        finish = (count == CW'(1));
`ifdef SR_MDU_EARLY_OUT_EN
        remMask = ~({WIDTH{1'b1}} << count);
        shifted = {accHi, accLo} >> count;
        mulIdle = !opReg[1] && ((accLo & remMask) == '0);
        if (mulIdle) begin
            nextHi = shifted[2*WIDTH-1:WIDTH];
            nextLo = shifted[WIDTH-1:0];
            finish = 1'b1;
        end
`endif
        // MUL/DIVU read the low half, MULHU/REMU the high half.
        resNext = opReg[0] ? nextHi : nextLo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            opReg   <= '0;
            operand <= '0;
            accHi   <= '0;
            accLo   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opReg   <= op;
                            accHi   <= '0;
                            accLo   <= op[1] ? srcA : srcB;
                            operand <= op[1] ? srcB : srcA;
                            count   <= CW'(WIDTH);
                            busy    <= 1'b1;
                            if (op[1] && (srcB == '0)) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                result <= op[0] ? srcA : '1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        accHi <= nextHi;
                        accLo <= nextLo;
                        count <= count - CW'(1);
                        if (finish) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= resNext;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_mdu_seq.sv
// Self-checking bench for sr_mdu_seq: latency/arithmetic reference model plus directed literal cases.
module tb_sr_mdu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    sr_mdu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] refResult(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'd0: return p[W-1:0];
            2'd1: return p[2*W-1:W];
            2'd2: return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // cycles from the accepting cycle to the done cycle
    function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] b);
        int k;
        if (o[1]) return (b == '0) ? 1 : W + 1;
`ifdef SR_MDU_EARLY_OUT_EN
        if (b == '0) return 2;
        k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i;
        return (k + 1 < W) ? k + 3 : W + 1;
`else
        k = 0;
        return W + 1 + k;
`endif
    endfunction

    logic         mBusy = 1'b0;
    logic         mDone = 1'b0;
    logic [W-1:0] mResult = '0;
    logic [W-1:0] mPend = '0;
    int           mLeft = 0;
    int           nAccepted = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mResult = '0;
        end else if (flush) begin
            mBusy = 1'b0;
            mDone = 1'b0;
        end else if (mBusy) begin
            if (mDone) begin
                mBusy = 1'b0;
                mDone = 1'b0;
            end else begin
                mLeft--;
                if (mLeft == 0) begin
                    mDone   = 1'b1;
                    mResult = mPend;
                end
            end
        end else if (start) begin
            nAccepted++;
            mPend = refResult(op, srcA, srcB);
            mLeft = refLatency(op, srcB) - 1;
            mBusy = 1'b1;
            if (mLeft == 0) begin
                mDone   = 1'b1;
                mResult = mPend;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model busy", W'(busy), W'(mBusy));
            check("model done", W'(done), W'(mDone));
            check("model result", result, mResult);
        end
    end

    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] expRes, input int expLat);
        int k;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        k     = 0;
        seen  = 1'b0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done) seen = 1'b1;
        end
        check({name, " done seen"}, W'(seen), W'(1));
        check({name, " latency"}, W'(k), W'(expLat));
        check({name, " result"}, result, expRes);
    endtask

    function automatic logic [W-1:0] randVal();
        case ($urandom % 4)
            0: return W'($urandom % 16);
            1: return W'($urandom);
            2: return W'(1) << ($urandom % W);
            default: return '1 - W'($urandom % 4);
        endcase
    endfunction

`ifdef SR_MDU_EARLY_OUT_EN
    localparam int LAT_MUL76 = 5;
    localparam int LAT_MUL0  = 2;
    localparam int LAT_MUL32 = 4;
`else
    localparam int LAT_MUL76 = 33;
    localparam int LAT_MUL0  = 33;
    localparam int LAT_MUL32 = 33;
`endif

    initial begin
        int  k;
        int  base;
        int  budget;
        int  doneCount;
        bit  seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, '0);

        // reset in the middle of a multiply
        start = 1'b1;
        op    = 2'd0;
        srcA  = 32'd123;
        srcB  = 32'hF00D_F00D;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", W'(busy), W'(0));
        check("async reset done", W'(done), W'(0));
        check("async reset result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("MUL 7*6", 2'd0, 32'd7, 32'd6, 32'd42, LAT_MUL76);
        runOp("MULHU ff*ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runOp("DIVU 100/7", 2'd2, 32'd100, 32'd7, 32'd14, 33);
        runOp("REMU 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 33);
        runOp("DIVU 5/0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        runOp("REMU 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 1);
        runOp("MUL 1234*0", 2'd0, 32'h1234, 32'd0, 32'd0, LAT_MUL0);
        runOp("MUL 3*2", 2'd0, 32'd3, 32'd2, 32'd6, LAT_MUL32);

        // start kept high with changing operands while busy, then held through DONE
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        srcA  = 32'd7;
        srcB  = 32'd6;
        seen  = 1'b0;
        k     = 0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            op   = 2'($urandom);
            srcA = W'($urandom);
            srcB = W'($urandom);
        end
        check("ignored start done seen", W'(seen), W'(1));
        check("ignored start result", result, 32'd42);
        op   = 2'd2;
        srcA = 32'd100;
        srcB = 32'd7;
        @(negedge clk);
        check("held start idle gap busy", W'(busy), W'(0));
        @(negedge clk);
        start = 1'b0;
        check("held start accepted", W'(busy), W'(1));
        seen = 1'b0;
        k    = 0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        check("back-to-back DIVU latency", W'(k), W'(32));
        check("back-to-back DIVU result", result, 32'd14);

        runOp("MUL 7*6 again", 2'd0, 32'd7, 32'd6, 32'd42, LAT_MUL76);

        // flush in the middle of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 2'd2;
        srcA  = 32'd1000;
        srcB  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", W'(busy), W'(0));
        check("flush done", W'(done), W'(0));
        check("flush result kept", result, 32'd42);
        doneCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        check("no done after flush", W'(doneCount), W'(0));
        start = 1'b1;
        flush = 1'b1;
        op    = 2'd0;
        srcA  = 32'd9;
        srcB  = 32'd9;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush beats start", W'(busy), W'(0));

        // randomized traffic against the model
        base   = nAccepted;
        budget = 0;
        while ((nAccepted - base) < 1000 && budget < 80000) begin
            @(negedge clk);
            budget++;
            start = ($urandom % 3) != 0;
            flush = ($urandom % 100) == 0;
            op    = 2'($urandom);
            srcA  = randVal();
            srcB  = randVal();
        end
        start = 1'b0;
        flush = 1'b0;
        check("random ops accepted", W'((nAccepted - base) >= 1000), W'(1));
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
